// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the iterative signed/unsigned divider.
package div_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_ITER  = 32;
  localparam int unsigned DIV_CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RUN   = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_cond_neg.sv
// Conditional two's-complement: out = neg ? -in : in.
module div_cond_neg #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_i,
  output logic [W-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/div.sv
// Iterative restoring divider, one quotient bit per cycle; hi = remainder, low = quotient.
// Optional DIV_UNSIGNED_EN adds the divu port for unsigned (DIVU) operation.
module div
  import div_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_ITER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] value_A,
  input  logic [DATA_W-1:0] value_B,
  input  logic              divInit,
`ifdef DIV_UNSIGNED_EN
  input  logic              divu,
`endif
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] low,
  output logic              divStop,
  output logic              divZero
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] low_q, low_d;
  logic              stop_q, stop_d;
  logic              zero_q, zero_d;

  logic              is_unsigned;
  logic [DATA_W-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [DATA_W:0]   shift;
  logic [DATA_W-1:0] trial;

`ifdef DIV_UNSIGNED_EN
  assign is_unsigned = divu;
`else
  assign is_unsigned = 1'b0;
`endif

  // Quotient register holds the dividend until it is shifted out during RUN.
  div_cond_neg #(.W(DATA_W)) u_mag_a (.in_i(quo_q), .neg_i(neg_a_q),           .out_o(a_mag));
  div_cond_neg #(.W(DATA_W)) u_mag_b (.in_i(dvs_q), .neg_i(neg_b_q),           .out_o(b_mag));
  div_cond_neg #(.W(DATA_W)) u_fix_q (.in_i(quo_q), .neg_i(neg_a_q ^ neg_b_q), .out_o(q_fix));
  div_cond_neg #(.W(DATA_W)) u_fix_r (.in_i(rem_q), .neg_i(neg_a_q),           .out_o(r_fix));

  // Shifted partial remainder needs the extra bit when the divisor magnitude uses bit 31.
  assign shift = {rem_q, quo_q[DATA_W-1]};
  assign trial = shift[DATA_W-1:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    hi_d    = hi_q;
    low_d   = low_q;
    stop_d  = 1'b0;
    zero_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (divInit) begin
          if (value_B == '0) begin
            state_d = DONE;
            stop_d  = 1'b1;
            zero_d  = 1'b1;
          end else begin
            quo_d   = value_A;
            dvs_d   = value_B;
            neg_a_d = value_A[DATA_W-1] & ~is_unsigned;
            neg_b_d = value_B[DATA_W-1] & ~is_unsigned;
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        quo_d   = a_mag;
        dvs_d   = b_mag;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        quo_d = {quo_q[DATA_W-2:0], 1'b0};
        if (shift >= {1'b0, dvs_q}) begin
          rem_d    = trial;
          quo_d[0] = 1'b1;
        end else begin
          rem_d = shift[DATA_W-1:0];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        low_d   = q_fix;
        hi_d    = r_fix;
        stop_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      hi_q    <= '0;
      low_q   <= '0;
      stop_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      hi_q    <= hi_d;
      low_q   <= low_d;
      stop_q  <= stop_d;
      zero_q  <= zero_d;
    end
  end

  assign hi      = hi_q;
  assign low     = low_q;
  assign divStop = stop_q;
  assign divZero = zero_q;

endmodule
